// File: rtl/buscycle_ctrl.sv
// 68030 asynchronous bus-cycle controller: region decode, wait states, dynamic-size acks, overlay, AVEC, BERR.
// Optional external-cycle watchdog enabled by defining BUSCTL_WATCHDOG_EN.
module buscycle_ctrl #(
  parameter int          NUM_REGIONS = 4,
  parameter logic [7:0]  REGION_EN   = 8'h01,
  parameter logic [31:0] REGION_WAIT = 32'h0000_0003,
  parameter logic [15:0] REGION_PORT = 16'h0000,
  parameter int          MODE_SEL    = 3,
  parameter int          WDOG_CYCLES = 64
) (
  input  logic                   sysClk,
  input  logic                   nReset,
  input  logic                   nAS,
  input  logic                   addr31,
  input  logic [2:0]             addrSel,
  input  logic                   RnW,
  input  logic [2:0]             cpuFC,
  output logic [NUM_REGIONS-1:0] nCE,
  output logic                   nMemRd,
  output logic                   nMemWr,
  output logic [1:0]             nDsack,
  output logic                   nBerr,
  output logic                   nAvec,
  output logic                   overlay,
  output logic [2:0]             busState
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_TERM   = 3'd3,
    ST_BERR   = 3'd4,
    ST_MODE   = 3'd5,
    ST_AVEC   = 3'd6,
    ST_END    = 3'd7
  } state_t;

  state_t     state;
  logic [2:0] regIdx;
  logic [3:0] regWait;
  logic [1:0] regPort;
  logic       isRead;
  logic [3:0] waitCnt;

`ifdef BUSCTL_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdogCnt;
`endif

  assign busState = state;

  // Decode terms, only consumed while the FSM is in ST_IDLE.
  logic fcOk, avecHit, bootHit, regHit, modeHit;
  always_comb begin
    fcOk    = (cpuFC == 3'd1) || (cpuFC == 3'd2) || (cpuFC == 3'd5) || (cpuFC == 3'd6);
    avecHit = (cpuFC == 3'd7) && (addrSel == 3'd7);
    bootHit = !overlay && RnW && !addr31 && (addrSel == 3'd0) && fcOk;
    regHit  = addr31 && (int'(addrSel) < NUM_REGIONS) && REGION_EN[addrSel] && fcOk;
    modeHit = addr31 && (addrSel == 3'(MODE_SEL)) && !RnW && fcOk;
  end

  logic [NUM_REGIONS-1:0] ceMask;
  always_comb begin
    ceMask = '0;
    for (int i = 0; i < NUM_REGIONS; i++) ceMask[i] = (regIdx == 3'(i));
  end

  // Reserved port code 3 acks as 8-bit.
  logic [1:0] ackCode;
  always_comb begin
    case (regPort)
      2'd1:    ackCode = 2'b01;
      2'd2:    ackCode = 2'b00;
      default: ackCode = 2'b10;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (!nReset) begin
      state   <= ST_IDLE;
      overlay <= 1'b0;
      nCE     <= '1;
      nMemRd  <= 1'b1;
      nMemWr  <= 1'b1;
      nDsack  <= 2'b11;
      nBerr   <= 1'b1;
      nAvec   <= 1'b1;
      waitCnt <= '0;
      regIdx  <= '0;
      regWait <= '0;
      regPort <= '0;
      isRead  <= 1'b1;
`ifdef BUSCTL_WATCHDOG_EN
      wdogCnt <= '0;
`endif
    end else if (nAS) begin
      state  <= ST_IDLE;
      nCE    <= '1;
      nMemRd <= 1'b1;
      nMemWr <= 1'b1;
      nDsack <= 2'b11;
      nBerr  <= 1'b1;
      nAvec  <= 1'b1;
`ifdef BUSCTL_WATCHDOG_EN
      wdogCnt <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (avecHit) begin
            state <= ST_AVEC;
          end else if (bootHit || regHit) begin
            regIdx  <= addrSel;
            regWait <= REGION_WAIT[{addrSel, 2'b00} +: 4];
            regPort <= REGION_PORT[{addrSel, 1'b0} +: 2];
            isRead  <= RnW;
            state   <= ST_ACTIVE;
          end else if (modeHit) begin
            state <= ST_MODE;
          end else if (addr31) begin
            state <= ST_BERR;
          end else begin
`ifdef BUSCTL_WATCHDOG_EN
            // External RAM cycle that never terminates gets a bus error.
            if (wdogCnt == WDOG_W'(WDOG_CYCLES - 1)) begin
              nBerr <= 1'b0;
              state <= ST_END;
            end else begin
              wdogCnt <= wdogCnt + 1'b1;
            end
`else
            state <= ST_IDLE;
`endif
          end
        end
        ST_ACTIVE: begin
          nCE     <= ~ceMask;
          nMemRd  <= !isRead;
          nMemWr  <= isRead;
          waitCnt <= regWait;
          state   <= (regWait != 4'd0) ? ST_WAIT : ST_TERM;
        end
        // Leaving on count==1 gives W+1 clocks from chip select to ack.
        ST_WAIT: begin
          waitCnt <= waitCnt - 4'd1;
          if (waitCnt <= 4'd1) state <= ST_TERM;
        end
        ST_TERM: begin
          nDsack <= ackCode;
          state  <= ST_END;
        end
        ST_BERR: begin
          nBerr <= 1'b0;
          state <= ST_END;
        end
        ST_AVEC: begin
          nAvec <= 1'b0;
          state <= ST_END;
        end
        ST_MODE: begin
          overlay <= ~overlay;
          nDsack  <= 2'b10;
          state   <= ST_END;
        end
        ST_END: begin
          nMemWr <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buscycle_ctrl.sv
// Directed bench for buscycle_ctrl: 8 regions, regions 0/1/4 enabled, MODE_SEL=3.
// Expected values are hand-derived from the bus-cycle timing (E0 = first edge with nAS low).
module tb_buscycle_ctrl;

  logic       sysClk;
  logic       nReset;
  logic       nAS;
  logic       addr31;
  logic [2:0] addrSel;
  logic       RnW;
  logic [2:0] cpuFC;
  logic [7:0] nCE;
  logic       nMemRd;
  logic       nMemWr;
  logic [1:0] nDsack;
  logic       nBerr;
  logic       nAvec;
  logic       overlay;
  logic [2:0] busState;

  int vecCount = 0;
  int missCount = 0;

  buscycle_ctrl #(
    .NUM_REGIONS(8),
    .REGION_EN(8'h13),
    .REGION_WAIT(32'h0005_0003),
    .REGION_PORT(16'h0108),
    .MODE_SEL(3),
    .WDOG_CYCLES(64)
  ) dut (
    .sysClk(sysClk),
    .nReset(nReset),
    .nAS(nAS),
    .addr31(addr31),
    .addrSel(addrSel),
    .RnW(RnW),
    .cpuFC(cpuFC),
    .nCE(nCE),
    .nMemRd(nMemRd),
    .nMemWr(nMemWr),
    .nDsack(nDsack),
    .nBerr(nBerr),
    .nAvec(nAvec),
    .overlay(overlay),
    .busState(busState)
  );

  // Clock / reset
  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one active edge; outputs are then sampled 1ns later.
  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic startCycle(input logic a31, input logic [2:0] sel, input logic rnw, input logic [2:0] fc);
    addr31  = a31;
    addrSel = sel;
    RnW     = rnw;
    cpuFC   = fc;
    nAS     = 1'b0;
    tick();
  endtask

  task automatic checkIdle(input string tag);
    checkVal({tag, "_nCE"}, 32'(nCE), 32'hFF);
    checkVal({tag, "_nMemRd"}, 32'(nMemRd), 32'h1);
    checkVal({tag, "_nMemWr"}, 32'(nMemWr), 32'h1);
    checkVal({tag, "_nDsack"}, 32'(nDsack), 32'h3);
    checkVal({tag, "_nBerr"}, 32'(nBerr), 32'h1);
    checkVal({tag, "_nAvec"}, 32'(nAvec), 32'h1);
    checkVal({tag, "_state"}, 32'(busState), 32'h0);
  endtask

  task automatic endCycle(input string tag);
    nAS = 1'b1;
    tick();
    checkIdle(tag);
  endtask

  initial begin
    nReset = 1'b0; nAS = 1'b1; addr31 = 1'b0; addrSel = 3'd0; RnW = 1'b1; cpuFC = 3'd0;
    tick(); tick();
    checkIdle("reset");
    checkVal("reset_overlay", 32'(overlay), 32'h0);
    nReset = 1'b1;
    tick();

    // Boot read of page 0, region 0: W=3, 8-bit.
    startCycle(1'b0, 3'd0, 1'b1, 3'd5);
    checkVal("rd0_E0_state", 32'(busState), 32'h1);
    checkVal("rd0_E0_nCE", 32'(nCE), 32'hFF);
    tick();
    checkVal("rd0_E1_nCE", 32'(nCE), 32'hFE);
    checkVal("rd0_E1_nMemRd", 32'(nMemRd), 32'h0);
    checkVal("rd0_E1_nMemWr", 32'(nMemWr), 32'h1);
    addrSel = 3'd5; RnW = 1'b0;  // late changes must be ignored
    tick(); tick(); tick();
    checkVal("rd0_E4_nDsack", 32'(nDsack), 32'h3);
    checkVal("rd0_E4_nMemRd", 32'(nMemRd), 32'h0);
    tick();
    checkVal("rd0_E5_nDsack", 32'(nDsack), 32'h2);
    checkVal("rd0_E5_state", 32'(busState), 32'h7);
    tick();
    checkVal("rd0_hold_nDsack", 32'(nDsack), 32'h2);
    checkVal("rd0_hold_nCE", 32'(nCE), 32'hFE);
    endCycle("rd0_end");

    // Mode write toggles the overlay on.
    startCycle(1'b1, 3'd3, 1'b0, 3'd5);
    checkVal("mode1_E0_state", 32'(busState), 32'h5);
    tick();
    checkVal("mode1_E1_nDsack", 32'(nDsack), 32'h2);
    checkVal("mode1_E1_overlay", 32'(overlay), 32'h1);
    checkVal("mode1_E1_nCE", 32'(nCE), 32'hFF);
    endCycle("mode1_end");
    checkVal("mode1_keep_overlay", 32'(overlay), 32'h1);

    // Page 0 read with overlay on is an external RAM cycle.
    startCycle(1'b0, 3'd0, 1'b1, 3'd5);
    tick(); tick();
    checkVal("ovl_rd_nCE", 32'(nCE), 32'hFF);
    checkVal("ovl_rd_nDsack", 32'(nDsack), 32'h3);
    checkVal("ovl_rd_state", 32'(busState), 32'h0);
    endCycle("ovl_rd_end");

    // Second mode write toggles it back off.
    startCycle(1'b1, 3'd3, 1'b0, 3'd6);
    tick();
    checkVal("mode2_overlay", 32'(overlay), 32'h0);
    checkVal("mode2_nDsack", 32'(nDsack), 32'h2);
    endCycle("mode2_end");

    // Region 1 write: W=0, 32-bit port.
    startCycle(1'b1, 3'd1, 1'b0, 3'd1);
    tick();
    checkVal("r1_E1_nCE", 32'(nCE), 32'hFD);
    checkVal("r1_E1_nMemWr", 32'(nMemWr), 32'h0);
    checkVal("r1_E1_nMemRd", 32'(nMemRd), 32'h1);
    tick();
    checkVal("r1_E2_nDsack", 32'(nDsack), 32'h0);
    checkVal("r1_E2_nMemWr", 32'(nMemWr), 32'h0);
    tick();
    checkVal("r1_E3_nMemWr", 32'(nMemWr), 32'h1);
    checkVal("r1_E3_nDsack", 32'(nDsack), 32'h0);
    checkVal("r1_E3_nCE", 32'(nCE), 32'hFD);
    endCycle("r1_end");

    // Unimplemented region 2 takes a bus error.
    startCycle(1'b1, 3'd2, 1'b1, 3'd5);
    checkVal("berr_E0_state", 32'(busState), 32'h4);
    tick();
    checkVal("berr_E1_nBerr", 32'(nBerr), 32'h0);
    checkVal("berr_E1_nCE", 32'(nCE), 32'hFF);
    endCycle("berr_end");

    // Enabled region but CPU space FC=7 (not addrSel 7) is still unmapped.
    startCycle(1'b1, 3'd1, 1'b1, 3'd7);
    tick();
    checkVal("fc7_nBerr", 32'(nBerr), 32'h0);
    checkVal("fc7_nCE", 32'(nCE), 32'hFF);
    endCycle("fc7_end");

    // Interrupt acknowledge autovector.
    startCycle(1'b1, 3'd7, 1'b1, 3'd7);
    checkVal("avec_E0_state", 32'(busState), 32'h6);
    tick();
    checkVal("avec_E1_nAvec", 32'(nAvec), 32'h0);
    checkVal("avec_E1_nBerr", 32'(nBerr), 32'h1);
    endCycle("avec_end");

    // Region 4: W=5, 16-bit port; ack 6 clocks after chip select.
    startCycle(1'b1, 3'd4, 1'b1, 3'd2);
    tick();
    checkVal("r4_E1_nCE", 32'(nCE), 32'hEF);
    repeat (5) tick();
    checkVal("r4_E6_state", 32'(busState), 32'h3);
    checkVal("r4_E6_nDsack", 32'(nDsack), 32'h3);
    tick();
    checkVal("r4_E7_nDsack", 32'(nDsack), 32'h1);
    endCycle("r4_end");

    // Reset in the middle of a W=5 wait with the overlay set.
    startCycle(1'b1, 3'd3, 1'b0, 3'd5);
    tick();
    nAS = 1'b1;
    tick();
    checkVal("rst_pre_overlay", 32'(overlay), 32'h1);
    startCycle(1'b1, 3'd4, 1'b1, 3'd5);
    tick(); tick();
    checkVal("rst_pre_state", 32'(busState), 32'h2);
    checkVal("rst_pre_nCE", 32'(nCE), 32'hEF);
    nReset = 1'b0;
    tick();
    checkIdle("rst_mid");
    checkVal("rst_mid_overlay", 32'(overlay), 32'h0);
    nReset = 1'b1; nAS = 1'b1;
    tick();

    // External RAM cycle with nAS held low for 100 clocks.
    startCycle(1'b0, 3'd1, 1'b1, 3'd5);
    repeat (62) tick();
    checkVal("wdog_e63_nBerr", 32'(nBerr), 32'h1);
    tick();
`ifdef BUSCTL_WATCHDOG_EN
    checkVal("wdog_e64_nBerr", 32'(nBerr), 32'h0);
`else
    checkVal("wdog_e64_nBerr", 32'(nBerr), 32'h1);
`endif
    repeat (36) tick();
`ifdef BUSCTL_WATCHDOG_EN
    checkVal("wdog_e100_nBerr", 32'(nBerr), 32'h0);
`else
    checkVal("wdog_e100_nBerr", 32'(nBerr), 32'h1);
`endif
    checkVal("wdog_nCE", 32'(nCE), 32'hFF);
    endCycle("wdog_end");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
